// File: rtl/gray_code_counter_pkg.sv
// Shared definitions for the Gray-code counter: default width, the terminal
// value for that width, and binary<->Gray conversion helpers for consumers.
package gray_code_counter_pkg;

    localparam int DEF_W = 3;
    localparam int MAXV  = (2 ** DEF_W) - 1;

    // Helpers work on a wide word; narrower values are zero-extended, which
    // leaves both conversions unchanged for any W up to MAX_W.
    localparam int MAX_W = 32;
    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_code_counter_bin_to_gray.sv
// Purely combinational binary-to-Gray converter: top bit passes through,
// every lower bit is the XOR of itself and its upper neighbour.
module bin_to_gray_n #(
    parameter int W = 3
) (
    input  logic [W-1:0] b,
    output logic [W-1:0] g
);

    assign g[W-1] = b[W-1];

    for (genvar i = 0; i < W - 1; i++) begin : g_xor
        assign g[i] = b[i+1] ^ b[i];
    end

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with wrap or saturate behaviour, a registered Gray
// copy of the count and a one-cycle terminal-count pulse.
module gray_code_counter
    import gray_code_counter_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic         tc
);

    localparam logic [W-1:0] MAX_VAL = '1;
    localparam logic [W-1:0] ZERO    = '0;
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    logic         at_max;
    logic         at_min;
    logic [W-1:0] bin_next;
    logic [W-1:0] gray_next;
    logic         tc_next;

    assign at_max = (bin == MAX_VAL);
    assign at_min = (bin == ZERO);

    // Next-state selection: load beats enable; a boundary step raises tc and
    // either wraps (carry/borrow discarded) or holds when saturating.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        bin_next = bin;
        tc_next  = 1'b0;
        if (load) begin
            bin_next = load_val;
        end else if (en) begin
            if (up) begin
                tc_next  = at_max;
                bin_next = (SAT && at_max) ? bin : bin + ONE;
            end else begin
                tc_next  = at_min;
                bin_next = (SAT && at_min) ? bin : bin - ONE;
            end
        end
    end

    // Gray is derived from the next-state binary so both registers stay coherent.
    bin_to_gray_n #(.W(W)) u_bin_to_gray (
        .b (bin_next),
        .g (gray_next)
    );

    // State registers with synchronous reset overriding load and enable.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            bin  <= ZERO;
            gray <= ZERO;
            tc   <= 1'b0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
            tc   <= tc_next;
        end
    end

endmodule
